fifo_splitter_n: RTL and testbench
==================================

Name: fifo_splitter_n

Overview:
- Parametrised 1-to-N broadcast splitter for the backprop datapath.
- Each accepted input word is copied into a private FIFO for every selected output channel.
- Slow consumers therefore no longer stall fast ones until their own FIFO fills.
- Replaces the single-buffer lock-step splitters; a per-word destination mask lets one stream feed a chosen subset of consumers.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- NUM_OUT, 4, number of output channels (>=2).
- DEPTH, 2, entries per output FIFO (power of two, >=2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  DATA_WIDTH  input payload.
- data_in_mask  in  NUM_OUT  destination select, bit i = channel i; qualified by data_in_valid.
- data_in_valid  in  1  input valid.
- data_in_ready  out  1  input ready.
- data_out  out  NUM_OUT*DATA_WIDTH  flattened outputs; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- data_out_valid  out  NUM_OUT  per-channel valid.
- data_out_ready  in  NUM_OUT  per-channel ready.

Behaviour:
- Reset: asynchronous on rst_n low; clears all FIFO pointers and counts.
  - data_out_valid = 0, data_in_ready = 0 while rst_n low, data_out = 0.
  - Stored payload is not cleared; data_out is zero-gated while valid is low.
- Ready: data_in_ready = 1 iff every channel count < DEPTH.
  - Depends on registered counts only; independent of data_in_mask and data_out_ready (no combinational ready path).
- Input handshake is data_in_valid & data_in_ready.
  - On handshake, data_in is pushed into FIFO i for every i with mask bit set.
  - Mask 0 means the word is consumed and dropped, with no channel push.
- Output: data_out_valid[i] = (count_i != 0); data_out slice i = head of FIFO i.
  - Pop on data_out_valid[i] & data_out_ready[i].
  - Latency from input handshake to data_out_valid is 1 cycle; no input-to-output bypass.
- Per-channel count width is $clog2(DEPTH+1).
  - Push only: +1. Pop only: -1. Push and pop in the same cycle: count unchanged, head advances, tail advances.
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Ordering: each channel delivers its words in input order.
  - Channels are mutually unsynchronised; channel i may run up to DEPTH words ahead of channel j.
- Full boundary: if any channel has count == DEPTH, data_in_ready = 0 that cycle, even if the mask excludes that channel.
  - A pop on the full channel raises data_in_ready on the following cycle.
- Empty boundary: data_out_ready asserted on an empty channel has no effect.
  - Counts never underflow or overflow.
- data_in_valid without ready: no state change.
  - Payload and mask may change freely; no hold requirement on the source.
- Reset mid-operation: all queued words are discarded and outputs go invalid asynchronously.
  - Consumers must not count on a partially delivered word being replayed.

Optional Feature:
- Macro: FIFO_SPLITTER_N_STATS_EN.
- Defined: adds two output ports, both cleared by rst_n.
  - stat_words_in, out, 32 bits: counts input handshakes, wraps at 2^32.
  - stat_stall_cycles, out, 32 bits: counts cycles with data_in_valid & ~data_in_ready, saturates at 0xFFFFFFFF.
- Undefined: ports and counters are absent; core behaviour is identical.

Decomposition:
- Shared package fifo_splitter_pkg holds:
  - Function clog2-based count/pointer width helpers.
  - Localparam default widths.
  - Constant STAT_W = 32.
- One natural sub-module, sync_fifo_ch: single-channel DEPTH-entry register FIFO.
  - Ports: push, din, pop, dout, count, empty, full; same reset.
  - Instantiated NUM_OUT times in a generate loop.
- The top level contains only ready AND-reduction, mask gating of push, and flattening.

Test Plan:
- Broadcast: NUM_OUT=4, DEPTH=2, all ready high, push 0xA5A5_0001 with mask 4'b1111 -> data_out_valid=4'b1111 next cycle, every slice 0xA5A5_0001, all valids cleared the following cycle.
- Subset and drop: push 0x11 with mask 4'b0101, then 0x22 with mask 4'b0000 -> only channels 0 and 2 show 0x11; 0x22 appears nowhere; both handshakes complete.
- Decoupling/backpressure:
  - Hold data_out_ready[3]=0, others high; stream 0x1,0x2,0x3 with full mask.
  - Expect: channels 0-2 drain; after 2 words data_in_ready=0; 0x3 blocked.
  - Release ready[3]: ready rises one cycle later; channel 3 delivers 0x1,0x2,0x3 in order.
- Simultaneous push/pop: channel 0 count=1, push and pop same cycle -> count stays 1, head advances; pointer wrap verified over 3*DEPTH words with no loss or duplication.
- Async reset: assert rst_n low mid-clock with 2 words queued -> data_out_valid=0 and data_in_ready=0 immediately; after release, no stale words are delivered.
- Stats (FIFO_SPLITTER_N_STATS_EN defined): 5 handshakes plus 3 blocked valid cycles -> stat_words_in=5, stat_stall_cycles=3; preset counter near max to confirm stall saturates and words wraps.

Source files
------------

// File: rtl/fifo_splitter_pkg.sv
// Shared widths and helpers for the 1-to-N broadcast splitter.
package fifo_splitter_pkg;

  localparam int STAT_W         = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_OUT    = 4;
  localparam int DEF_DEPTH      = 2;

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_splitter_n_sync_fifo_ch.sv
// Single-channel register FIFO; payload storage is not reset, head is zero-gated when empty.
module sync_fifo_ch
  import fifo_splitter_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  localparam int CW         = cnt_w(DEPTH),
  localparam int PW         = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fifo_splitter_n.sv
// 1-to-N broadcast splitter with a private FIFO per output channel.
// Optional statistics counters are enabled by FIFO_SPLITTER_N_STATS_EN.
module fifo_splitter_n
  import fifo_splitter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_OUT    = DEF_NUM_OUT,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic [NUM_OUT-1:0]            data_in_mask,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0] data_out,
  output logic [NUM_OUT-1:0]            data_out_valid,
  input  logic [NUM_OUT-1:0]            data_out_ready
`ifdef FIFO_SPLITTER_N_STATS_EN
  ,
  output logic [STAT_W-1:0]             stat_words_in,
  output logic [STAT_W-1:0]             stat_stall_cycles
`endif
);

  localparam int CW = cnt_w(DEPTH);

  logic [CW-1:0]      ch_count [NUM_OUT];
  logic [NUM_OUT-1:0] ch_empty, ch_full, ch_push;
  logic               all_room, in_hs;

  // Ready looks only at registered occupancy, never at mask or consumer ready.
  always_comb begin
    all_room = 1'b1;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (ch_count[i] >= CW'(DEPTH)) all_room = 1'b0;
    end
  end

  assign data_in_ready  = all_room & rst_n;
  assign in_hs          = data_in_valid & data_in_ready;
  assign ch_push        = {NUM_OUT{in_hs}} & data_in_mask & ~ch_full;
  assign data_out_valid = ~ch_empty;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_ch
    sync_fifo_ch #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (ch_push[i]),
      .din   (data_in),
      .pop   (data_out_ready[i]),
      .dout  (data_out[i*DATA_WIDTH +: DATA_WIDTH]),
      .count (ch_count[i]),
      .empty (ch_empty[i]),
      .full  (ch_full[i])
    );
  end

`ifdef FIFO_SPLITTER_N_STATS_EN
  logic [STAT_W-1:0] stat_words_q, stat_words_d;
  logic [STAT_W-1:0] stat_stall_q, stat_stall_d;

  // Word count wraps; stall count sticks at all-ones.
  always_comb begin
    stat_words_d = stat_words_q;
    stat_stall_d = stat_stall_q;
    if (in_hs) stat_words_d = stat_words_q + STAT_W'(1);
    if (data_in_valid && !data_in_ready && (stat_stall_q != '1))
      stat_stall_d = stat_stall_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_words_in     = stat_words_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_fifo_splitter_n.sv
// Randomised and directed bench for fifo_splitter_n against a queue-based reference model.
module tb_fifo_splitter_n;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int D  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   data_in = '0;
  logic [N-1:0]    data_in_mask = '0;
  logic            data_in_valid = 1'b0;
  logic            data_in_ready;
  logic [N*DW-1:0] data_out;
  logic [N-1:0]    data_out_valid;
  logic [N-1:0]    data_out_ready = '0;
`ifdef FIFO_SPLITTER_N_STATS_EN
  logic [31:0]     stat_words_in;
  logic [31:0]     stat_stall_cycles;
`endif

  int tests_run = 0;
  int failures  = 0;

  logic [DW-1:0] mq [N][$];

  always #5 clk = ~clk;

  fifo_splitter_n #(.DATA_WIDTH(DW), .NUM_OUT(N), .DEPTH(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_in_mask   (data_in_mask),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
`ifdef FIFO_SPLITTER_N_STATS_EN
    ,
    .stat_words_in     (stat_words_in),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  function automatic logic exp_ready();
    for (int i = 0; i < N; i++) if (mq[i].size() >= D) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = (mq[i].size() != 0);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] exp_data();
    logic [N*DW-1:0] r = '0;
    for (int i = 0; i < N; i++) if (mq[i].size() != 0) r[i*DW +: DW] = mq[i][0];
    return r;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) mq[i].delete();
  endfunction

  // One clock: apply inputs, let the edge pass, update the model, leave time at edge+1.
  task automatic advance(input logic v, input logic [N-1:0] m, input logic [DW-1:0] d,
                         input logic [N-1:0] r);
    logic         hs;
    logic [N-1:0] pop;
    data_in_valid  = v;
    data_in_mask   = m;
    data_in        = d;
    data_out_ready = r;
    hs = v && exp_ready();
    for (int i = 0; i < N; i++) pop[i] = r[i] && (mq[i].size() != 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pop[i]) void'(mq[i].pop_front());
      if (hs && m[i]) mq[i].push_back(d);
    end
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if (data_out_valid !== '0 || data_in_ready !== 1'b0 || data_out !== '0) begin
      failures++;
      $display("FAIL reset_hold: valid=%b ready=%b data=%h, want 0/0/0",
               data_out_valid, data_in_ready, data_out);
    end
    rst_n = 1'b1;
    advance(1'b0, '0, '0, '1);
    tests_run++;
    if (data_out_valid !== '0 || data_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: valid=%b ready=%b, want 0000/1", data_out_valid, data_in_ready);
    end
  endtask

  task automatic test_broadcast();
    advance(1'b1, 4'b1111, 32'hA5A5_0001, '1);
    tests_run++;
    if (data_out_valid !== 4'b1111 || data_out !== {4{32'hA5A5_0001}}) begin
      failures++;
      $display("FAIL broadcast: valid=%b data=%h, want 1111 and 4xa5a50001", data_out_valid, data_out);
    end
    advance(1'b0, '0, '0, '1);
    tests_run++;
    if (data_out_valid !== '0 || data_out_valid !== exp_valid()) begin
      failures++;
      $display("FAIL broadcast_clear: valid=%b want 0000", data_out_valid);
    end
  endtask

  task automatic test_subset_drop();
    logic hs1, hs2;
    data_in_valid = 1'b1;
    advance(1'b1, 4'b0101, 32'h11, 4'b0000);
    hs1 = 1'b1;
    tests_run++;
    if (data_out_valid !== 4'b0101 || data_out !== {32'h0, 32'h11, 32'h0, 32'h11} ||
        data_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL subset: valid=%b ready=%b data=%h, want 0101 / 1", data_out_valid,
               data_in_ready, data_out);
    end
    hs2 = data_in_ready;
    advance(1'b1, 4'b0000, 32'h22, 4'b0000);
    tests_run++;
    if (!(hs1 && hs2) || data_out_valid !== 4'b0101 || data_out !== exp_data() ||
        data_out !== {32'h0, 32'h11, 32'h0, 32'h11}) begin
      failures++;
      $display("FAIL drop: hs2=%b valid=%b data=%h, want 1/0101 with no 0x22", hs2,
               data_out_valid, data_out);
    end
    advance(1'b0, '0, '0, '1);
    tests_run++;
    if (data_out_valid !== '0) begin
      failures++;
      $display("FAIL subset_drain: valid=%b want 0000", data_out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got3 [$];
    logic [DW-1:0] w;
    advance(1'b1, 4'b1111, 32'h1, 4'b0111);
    advance(1'b1, 4'b1111, 32'h2, 4'b0111);
    tests_run++;
    if (data_in_ready !== 1'b0 || data_out_valid !== 4'b1111 || data_out !== exp_data()) begin
      failures++;
      $display("FAIL bp_full: ready=%b valid=%b, want 0/1111", data_in_ready, data_out_valid);
    end
    advance(1'b1, 4'b1111, 32'h3, 4'b0111);
    tests_run++;
    if (data_in_ready !== 1'b0 || data_out_valid !== 4'b1000) begin
      failures++;
      $display("FAIL bp_blocked: ready=%b valid=%b, want 0/1000", data_in_ready, data_out_valid);
    end
    got3.push_back(data_out[3*DW +: DW]);
    advance(1'b1, 4'b1111, 32'h3, 4'b1111);
    tests_run++;
    if (data_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: ready=%b want 1", data_in_ready);
    end
    got3.push_back(data_out[3*DW +: DW]);
    advance(1'b1, 4'b1111, 32'h3, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      if (data_out_valid[3]) begin
        w = data_out[3*DW +: DW];
        if (got3.size() == 0 || got3[$] !== w) got3.push_back(w);
      end
      advance(1'b0, '0, '0, 4'b1111);
    end
    tests_run++;
    if (got3.size() != 3 || got3[0] !== 32'h1 || got3[1] !== 32'h2 || got3[2] !== 32'h3) begin
      failures++;
      $display("FAIL bp_order: ch3 got %0d words, want 1,2,3", got3.size());
    end
    tests_run++;
    if (data_out_valid !== '0 || data_out_valid !== exp_valid()) begin
      failures++;
      $display("FAIL bp_drain: valid=%b want 0000", data_out_valid);
    end
  endtask

  task automatic test_push_pop();
    logic [DW-1:0] w;
    int errs = 0;
    advance(1'b1, 4'b0001, 32'hC000_0000, 4'b0000);
    for (int k = 1; k <= 3 * D; k++) begin
      w = 32'hC000_0000 + k;
      advance(1'b1, 4'b0001, w, 4'b0001);
      if (data_out_valid !== 4'b0001 || data_out[DW-1:0] !== w || data_in_ready !== 1'b1)
        errs++;
    end
    tests_run++;
    if (errs != 0) begin
      failures++;
      $display("FAIL push_pop_wrap: %0d bad cycles, want 0", errs);
    end
    advance(1'b0, '0, '0, '1);
    tests_run++;
    if (data_out_valid !== '0) begin
      failures++;
      $display("FAIL push_pop_drain: valid=%b want 0000", data_out_valid);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      advance(($urandom % 4) != 0, N'($urandom), $urandom,
              N'($urandom) | N'($urandom));
      if (data_out_valid !== exp_valid() || data_out !== exp_data() ||
          data_in_ready !== exp_ready()) begin
        errs++;
        if (errs < 4)
          $display("FAIL random_cycle%0d: valid=%b/%b ready=%b/%b", c, data_out_valid,
                   exp_valid(), data_in_ready, exp_ready());
      end
    end
    tests_run++;
    if (errs != 0) begin
      failures++;
      $display("FAIL random: %0d mismatching cycles, want 0", errs);
    end
    for (int c = 0; c < 4; c++) advance(1'b0, '0, '0, '1);
  endtask

  task automatic test_async_reset();
    int errs = 0;
    advance(1'b1, 4'b1111, 32'hDEAD_0001, 4'b0000);
    advance(1'b1, 4'b1111, 32'hDEAD_0002, 4'b0000);
    data_in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (data_out_valid !== '0 || data_in_ready !== 1'b0 || data_out !== '0) begin
      failures++;
      $display("FAIL async_reset: valid=%b ready=%b data=%h, want 0/0/0", data_out_valid,
               data_in_ready, data_out);
    end
    model_clear();
    #10;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      advance(1'b0, '0, '0, '1);
      if (data_out_valid !== '0 || data_in_ready !== 1'b1) errs++;
    end
    tests_run++;
    if (errs != 0) begin
      failures++;
      $display("FAIL reset_stale: %0d cycles with stale data or no ready, want 0", errs);
    end
    advance(1'b1, 4'b0010, 32'h0BAD_F00D, '1);
    tests_run++;
    if (data_out_valid !== 4'b0010 || data_out !== exp_data()) begin
      failures++;
      $display("FAIL post_reset: valid=%b want 0010", data_out_valid);
    end
    advance(1'b0, '0, '0, '1);
  endtask

`ifdef FIFO_SPLITTER_N_STATS_EN
  task automatic test_stats();
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    tests_run++;
    if (stat_words_in !== '0 || stat_stall_cycles !== '0) begin
      failures++;
      $display("FAIL stats_reset: words=%0d stall=%0d want 0/0", stat_words_in, stat_stall_cycles);
    end
    #5;
    rst_n = 1'b1;
    advance(1'b1, 4'b0001, 32'h51, 4'b0000);
    advance(1'b1, 4'b0001, 32'h52, 4'b0000);
    for (int k = 0; k < 3; k++) advance(1'b1, 4'b0001, 32'h53, 4'b0000);
    advance(1'b0, '0, '0, 4'b0001);
    for (int k = 0; k < 3; k++) advance(1'b1, 4'b0001, 32'h60 + k, 4'b0001);
    advance(1'b0, '0, '0, '1);
    tests_run++;
    if (stat_words_in !== 32'd5 || stat_stall_cycles !== 32'd3) begin
      failures++;
      $display("FAIL stats_count: words=%0d stall=%0d want 5/3", stat_words_in, stat_stall_cycles);
    end
    for (int c = 0; c < 3; c++) advance(1'b0, '0, '0, '1);
  endtask
`endif

  initial begin
    test_reset();
    test_broadcast();
    test_subset_drop();
    test_backpressure();
    test_push_pop();
    test_random();
    test_async_reset();
`ifdef FIFO_SPLITTER_N_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
